// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-ported memory between fetch and data requesters
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_kill,
    output logic        if_ready,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ready,
    output logic [31:0] d_rdata,
    output logic        mem_valid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        bus_err
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [SW-1:0] STARVE_ONE = SW'(1);
    localparam logic [WW-1:0] WD_LAST    = (TIMEOUT > 0) ? WW'(TIMEOUT - 1) : '0;
    localparam logic [WW-1:0] WD_ONE     = WW'(1);

    typedef enum logic [1:0] {IDLE, D_ACC, I_ACC, RESP} state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [WW-1:0] wd_q, wd_d;
    logic          drop_q, drop_d;
    logic          mem_valid_q, mem_valid_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          if_ready_q, if_ready_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic          d_ready_q, d_ready_d;
    logic [31:0]   d_rdata_q, d_rdata_d;
    logic          bus_err_q, bus_err_d;
    logic          fetch_ok, is_fetch, fetch_dead, wd_expired;

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        wd_d        = wd_q;
        drop_d      = drop_q;
        mem_valid_d = mem_valid_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ready_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_ready_d   = 1'b0;
        d_rdata_d   = d_rdata_q;
        bus_err_d   = 1'b0;
        fetch_ok    = if_req & ~if_kill;
        is_fetch    = (state_q == I_ACC);
        fetch_dead  = is_fetch & (drop_q | if_kill);
        wd_expired  = (TIMEOUT != 0) && (wd_q == WD_LAST);

        case (state_q)
            IDLE: begin
                drop_d = 1'b0;
                wd_d   = '0;
                if (!if_req) begin
                    starve_d = '0;
                end
                if (d_req && !(fetch_ok && starve_q == STARVE_MAX)) begin
                    state_d     = D_ACC;
                    mem_valid_d = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    if (if_req && starve_q != STARVE_MAX) begin
                        starve_d = starve_q + STARVE_ONE;
                    end
                end else if (fetch_ok) begin
                    state_d     = I_ACC;
                    mem_valid_d = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    starve_d    = '0;
                end
            end
            D_ACC, I_ACC: begin
                if (is_fetch && if_kill) begin
                    drop_d = 1'b1;
                end
                if (mem_ready) begin
                    state_d     = RESP;
                    mem_valid_d = 1'b0;
                    if (is_fetch) begin
                        if (!fetch_dead) begin
                            if_ready_d = 1'b1;
                            if_rdata_d = mem_rdata;
                        end
                    end else begin
                        d_ready_d = 1'b1;
                        if (!mem_we_q) begin
                            d_rdata_d = mem_rdata;
                        end
                    end
                end else if (wd_expired) begin
                    // Timed-out access completes with an error; a flushed fetch stays silent.
                    state_d     = RESP;
                    mem_valid_d = 1'b0;
                    if (is_fetch) begin
                        if_ready_d = ~fetch_dead;
                        bus_err_d  = ~fetch_dead;
                    end else begin
                        d_ready_d = 1'b1;
                        bus_err_d = 1'b1;
                    end
                end else begin
                    wd_d = wd_q + WD_ONE;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            wd_q        <= '0;
            drop_q      <= 1'b0;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ready_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_ready_q   <= 1'b0;
            d_rdata_q   <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            wd_q        <= wd_d;
            drop_q      <= drop_d;
            mem_valid_q <= mem_valid_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ready_q  <= if_ready_d;
            if_rdata_q  <= if_rdata_d;
            d_ready_q   <= d_ready_d;
            d_rdata_q   <= d_rdata_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign if_ready  = if_ready_q;
    assign if_rdata  = if_rdata_q;
    assign d_ready   = d_ready_q;
    assign d_rdata   = d_rdata_q;
    assign mem_valid = mem_valid_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0, if_kill = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0, mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic        if_ready, d_ready, mem_valid, mem_we, bus_err;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

    int errors = 0;
    int checks = 0;

    logic [64:0] grant_q[$];
    logic [32:0] ifresp_q[$];
    logic [32:0] dresp_q[$];

    int          mem_lat = 0;
    logic [31:0] mem_data = '0;
    bit          mem_force = 1'b0;
    int          lat_cnt = 0;
    logic        prev_valid = 1'b0;

    mem_port_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_ready(if_ready), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Memory responder: mem_ready after mem_lat cycles of mem_valid; mem_lat < 0 never answers.
    always @(negedge clk) begin
        if (mem_force) begin
            mem_ready = 1'b1;
        end else if (mem_valid && !mem_ready) begin
            mem_ready = (mem_lat >= 0) && (lat_cnt == mem_lat);
            lat_cnt++;
        end else begin
            mem_ready = 1'b0;
            lat_cnt = 0;
        end
        mem_rdata = mem_data;
    end

    // Scoreboard: grants and responses popped in order of appearance.
    always @(negedge clk) begin
        if (mem_valid && !prev_valid) begin
            if (grant_q.size() == 0) check("grant_unexpected", grant_q.size(), 1);
            else check("grant", {mem_we, mem_addr, mem_wdata}, grant_q.pop_front());
        end
        prev_valid = mem_valid;
        if (if_ready) begin
            if (ifresp_q.size() == 0) check("if_ready_unexpected", ifresp_q.size(), 1);
            else check("if_resp", {bus_err, if_rdata}, ifresp_q.pop_front());
        end
        if (d_ready) begin
            if (dresp_q.size() == 0) check("d_ready_unexpected", dresp_q.size(), 1);
            else check("d_resp", {bus_err, d_rdata}, dresp_q.pop_front());
        end
    end

    task automatic run_reqs(input int d_total, input int max_cyc);
        int dcnt = 0;
        int n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (d_ready) begin
                dcnt++;
                if (dcnt >= d_total) d_req = 1'b0;
            end
            if (if_ready) if_req = 1'b0;
            if (!d_req && !if_req && !mem_valid && !d_ready && !if_ready) break;
            if (n >= max_cyc) begin
                check("run_bound", {d_req, if_req}, 0);
                d_req = 1'b0;
                if_req = 1'b0;
                break;
            end
        end
    endtask

    task automatic fetch_latency(input string tag, input logic [31:0] addr, input logic [31:0] data);
        int n = 0;
        mem_lat = 2;
        mem_data = data;
        grant_q.push_back({1'b0, addr, 32'h0});
        ifresp_q.push_back({1'b0, data});
        if_addr = addr;
        if_req = 1'b1;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (if_ready) break;
        end
        check(tag, n, 4);
        if_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n;
        int dcnt;
        int seen;
        repeat (3) @(negedge clk);
        check("rst_flags", {if_ready, d_ready, mem_valid, mem_we, bus_err}, 0);
        check("rst_data", {if_rdata, d_rdata, mem_addr}, 0);
        rst = 1'b0;
        @(negedge clk);

        // 1: lone fetch, two wait states
        fetch_latency("t1_latency", 32'h0040_0000, 32'h2108_0004);
        check("t1_if_rdata", if_rdata, 32'h2108_0004);

        // 2: simultaneous load and fetch, data first
        mem_lat = 0;
        mem_data = 32'h1111_2222;
        grant_q.push_back({1'b0, 32'h1000_0010, 32'h0});
        grant_q.push_back({1'b0, 32'h0040_0004, 32'h0});
        dresp_q.push_back({1'b0, 32'h1111_2222});
        ifresp_q.push_back({1'b0, 32'h1111_2222});
        d_we = 1'b0; d_addr = 32'h1000_0010; d_wdata = 32'h0;
        if_addr = 32'h0040_0004;
        d_req = 1'b1; if_req = 1'b1;
        run_reqs(1, 40);

        // 3: starvation guard: 4 data, 1 fetch, data again
        d_addr = 32'h1000_0020;
        if_addr = 32'h0040_0008;
        for (int i = 0; i < 4; i++) grant_q.push_back({1'b0, 32'h1000_0020, 32'h0});
        grant_q.push_back({1'b0, 32'h0040_0008, 32'h0});
        grant_q.push_back({1'b0, 32'h1000_0020, 32'h0});
        for (int i = 0; i < 5; i++) dresp_q.push_back({1'b0, 32'h1111_2222});
        ifresp_q.push_back({1'b0, 32'h1111_2222});
        d_req = 1'b1; if_req = 1'b1;
        run_reqs(5, 80);

        // 4: flushed fetch completes silently
        mem_lat = 3;
        mem_data = 32'hDEAD_BEEF;
        grant_q.push_back({1'b0, 32'h0040_0100, 32'h0});
        if_addr = 32'h0040_0100;
        if_req = 1'b1;
        n = 0;
        while (!mem_valid && n < 10) begin @(negedge clk); n++; end
        check("t4_granted", mem_valid, 1);
        if_kill = 1'b1; if_req = 1'b0;
        @(negedge clk);
        if_kill = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (if_ready) seen++;
        end
        check("t4_no_if_ready", seen, 0);
        check("t4_if_rdata_kept", if_rdata, 32'h1111_2222);
        check("t4_mem_idle", mem_valid, 0);
        fetch_latency("t4_back_in_idle", 32'h0040_0200, 32'h0BAD_F00D);

        // 5: store never answered, watchdog fires
        mem_lat = -1;
        grant_q.push_back({1'b1, 32'h1000_0000, 32'hCAFE_0001});
        dresp_q.push_back({1'b1, 32'h1111_2222});
        d_we = 1'b1; d_addr = 32'h1000_0000; d_wdata = 32'hCAFE_0001;
        d_req = 1'b1;
        n = 0;
        while (n < 30) begin
            @(negedge clk);
            n++;
            if (d_ready) break;
        end
        check("t5_timeout_latency", n, 9);
        check("t5_bus_err", {bus_err, mem_valid}, 2'b10);
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        check("t5_bus_err_pulse", bus_err, 0);

        // 6: reset mid data access after starve count built up
        mem_lat = 0;
        mem_data = 32'h3333_4444;
        d_addr = 32'h1000_0030; d_wdata = 32'h0;
        if_addr = 32'h0040_0300;
        for (int i = 0; i < 3; i++) begin
            grant_q.push_back({1'b0, 32'h1000_0030, 32'h0});
            dresp_q.push_back({1'b0, 32'h3333_4444});
        end
        d_req = 1'b1; if_req = 1'b1;
        dcnt = 0; n = 0;
        while (dcnt < 3 && n < 40) begin
            @(negedge clk);
            n++;
            if (d_ready) dcnt++;
        end
        check("t6_three_loads", dcnt, 3);
        mem_lat = -1;
        grant_q.push_back({1'b0, 32'h1000_0030, 32'h0});
        n = 0;
        do begin @(negedge clk); n++; end while (!mem_valid && n < 10);
        check("t6_in_d_acc", mem_valid, 1);
        rst = 1'b1; d_req = 1'b0; if_req = 1'b0; mem_force = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t6_rst_outs", {mem_valid, d_ready, if_ready, bus_err}, 0);
        check("t6_rst_rdata", {d_rdata, if_rdata}, 0);
        repeat (2) @(negedge clk);
        check("t6_late_ready_ignored", {mem_valid, d_ready, if_ready}, 0);
        mem_force = 1'b0;
        repeat (2) @(negedge clk);
        mem_lat = 0;
        grant_q.push_back({1'b0, 32'h1000_0030, 32'h0});
        grant_q.push_back({1'b0, 32'h0040_0300, 32'h0});
        dresp_q.push_back({1'b0, 32'h3333_4444});
        ifresp_q.push_back({1'b0, 32'h3333_4444});
        d_req = 1'b1; if_req = 1'b1;
        run_reqs(1, 40);

        repeat (3) @(negedge clk);
        check("grant_q_drained", grant_q.size(), 0);
        check("ifresp_q_drained", ifresp_q.size(), 0);
        check("dresp_q_drained", dresp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time exceeded");
        $fatal(1);
    end

endmodule
